// File: rtl/pwm_reg_master.sv
// pwm_reg_master: command/response bus initiator for the PWM register block.
// Optional boot sequencer enabled by defining PWM_REG_MASTER_BOOT_EN.
`default_nettype none

module pwm_reg_master #(
  parameter int               WIDTH          = 16,
  parameter int               MAX_ADDR       = 6,
  parameter logic [WIDTH-1:0] BOOT_PSC       = '0,
  parameter logic [WIDTH-1:0] BOOT_ARR       = WIDTH'(16'hFFFF),
  parameter logic [WIDTH-1:0] BOOT_CMP_START = '0,
  parameter logic [WIDTH-1:0] BOOT_CMP_END   = WIDTH'(16'h8000),
  parameter logic [WIDTH-1:0] BOOT_DTG       = WIDTH'(1),
  parameter logic [WIDTH-1:0] BOOT_CFG       = '0,
  parameter logic             BOOT_CEN       = 1'b1
) (
  input  logic             clk_psc_i,
  input  logic             rst_n_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic             cmd_write_i,
  input  logic [7:0]       cmd_addr_i,
  input  logic [WIDTH-1:0] cmd_wdata_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [WIDTH-1:0] rsp_rdata_o,
  output logic             rsp_err_o,
  output logic             wr_en_o,
  output logic             rd_en_o,
  output logic [7:0]       addr_o,
  output logic [WIDTH-1:0] wr_data_o,
  input  logic [WIDTH-1:0] rd_data_i,
  output logic             busy_o
);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_IDLE = 2'd1,
    S_BUS  = 2'd2,
    S_RESP = 2'd3
  } state_t;

`ifdef PWM_REG_MASTER_BOOT_EN
  localparam state_t RESET_STATE = S_BOOT;
`else
  localparam state_t RESET_STATE = S_IDLE;
`endif

  state_t           state_q;
  logic             cmd_ready_q;
  logic             busy_q;
  logic             wr_en_q;
  logic             rd_en_q;
  logic [7:0]       addr_q;
  logic [WIDTH-1:0] wdata_q;
  logic             err_q;
  logic             rsp_valid_q;
  logic [WIDTH-1:0] rsp_rdata_q;
  logic             rsp_err_q;
  logic             cmd_illegal;

  assign cmd_illegal = (32'(cmd_addr_i) > 32'(MAX_ADDR));

`ifdef PWM_REG_MASTER_BOOT_EN
  logic [2:0]       boot_idx_q;
  logic [7:0]       boot_addr;
  logic [WIDTH-1:0] boot_wdata;
  logic             boot_last_done;

  // Index 6 maps to addr 0 so the counter enable is written only after configuration.
  assign boot_addr      = (boot_idx_q == 3'd6) ? 8'd0 : 8'(boot_idx_q + 3'd1);
  assign boot_last_done = wr_en_q && (addr_q == 8'd0);

  always_comb begin
    boot_wdata = '0;
    case (boot_idx_q)
      3'd0:    boot_wdata = BOOT_PSC;
      3'd1:    boot_wdata = BOOT_ARR;
      3'd2:    boot_wdata = BOOT_CMP_START;
      3'd3:    boot_wdata = BOOT_CMP_END;
      3'd4:    boot_wdata = WIDTH'(BOOT_DTG[7:0]);
      3'd5:    boot_wdata = BOOT_CFG;
      default: boot_wdata = WIDTH'(BOOT_CEN);
    endcase
  end
`else
  logic unused_boot_params;
  assign unused_boot_params = ^{BOOT_PSC, BOOT_ARR, BOOT_CMP_START, BOOT_CMP_END,
                                BOOT_DTG, BOOT_CFG, BOOT_CEN};
`endif

  always_ff @(posedge clk_psc_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= RESET_STATE;
      cmd_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      wr_en_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      err_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
`ifdef PWM_REG_MASTER_BOOT_EN
      boot_idx_q  <= 3'd0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_valid_i && cmd_ready_q) begin
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            err_q       <= cmd_illegal;
            state_q     <= S_BUS;
            if (!cmd_illegal) begin
              wr_en_q <= cmd_write_i;
              rd_en_q <= !cmd_write_i;
              addr_q  <= cmd_addr_i;
              wdata_q <= cmd_write_i ? cmd_wdata_i : '0;
            end
          end else begin
            cmd_ready_q <= 1'b1;
          end
        end

        S_BUS: begin
          wr_en_q     <= 1'b0;
          rd_en_q     <= 1'b0;
          addr_q      <= '0;
          wdata_q     <= '0;
          rsp_valid_q <= 1'b1;
          rsp_rdata_q <= rd_en_q ? rd_data_i : '0;
          rsp_err_q   <= err_q;
          state_q     <= S_RESP;
        end

        S_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end

        S_BOOT: begin
`ifdef PWM_REG_MASTER_BOOT_EN
          if (boot_last_done) begin
            wr_en_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            busy_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
            boot_idx_q  <= 3'd0;
            state_q     <= S_IDLE;
          end else begin
            wr_en_q <= 1'b1;
            addr_q  <= boot_addr;
            wdata_q <= boot_wdata;
            busy_q  <= 1'b1;
            if (boot_idx_q != 3'd6) begin
              boot_idx_q <= boot_idx_q + 3'd1;
            end
          end
`else
          state_q <= S_IDLE;
`endif
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready_o = cmd_ready_q;
  assign busy_o      = busy_q;
  assign wr_en_o     = wr_en_q;
  assign rd_en_o     = rd_en_q;
  assign addr_o      = addr_q;
  assign wr_data_o   = wdata_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;

endmodule

`default_nettype wire

// File: tb/tb_pwm_reg_master.sv
// tb_pwm_reg_master: randomized command stream against a register-map reference model.
`default_nettype none

module tb_pwm_reg_master;

  localparam int WIDTH    = 16;
  localparam int MAX_ADDR = 6;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic             cmd_write = 1'b0;
  logic [7:0]       cmd_addr = '0;
  logic [WIDTH-1:0] cmd_wdata = '0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [WIDTH-1:0] rsp_rdata;
  logic             rsp_err;
  logic             wr_en;
  logic             rd_en;
  logic [7:0]       addr;
  logic [WIDTH-1:0] wr_data;
  logic [WIDTH-1:0] rd_data;
  logic             busy;

  int checks = 0;
  int failures = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;

  logic [WIDTH-1:0] bus_mem [0:7] = '{default: '0};
  logic [WIDTH-1:0] ref_mem [0:7];

  always #5 clk = ~clk;

  pwm_reg_master dut (
    .clk_psc_i   (clk),
    .rst_n_i     (rst_n),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_write_i (cmd_write),
    .cmd_addr_i  (cmd_addr),
    .cmd_wdata_i (cmd_wdata),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_rdata_o (rsp_rdata),
    .rsp_err_o   (rsp_err),
    .wr_en_o     (wr_en),
    .rd_en_o     (rd_en),
    .addr_o      (addr),
    .wr_data_o   (wr_data),
    .rd_data_i   (rd_data),
    .busy_o      (busy)
  );

  // Register block stand-in: combinational read, write on the clock edge.
  assign rd_data = bus_mem[addr[2:0]];
  always @(posedge clk) begin
    if (wr_en && addr <= 8'd6) bus_mem[addr[2:0]] <= wr_data;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("strobe_excl", 64'(wr_en & rd_en), 0);
        if (!wr_en && !rd_en) check("bus_idle_zero", {addr, wr_data}, 0);
        wr_cnt += int'(wr_en);
        rd_cnt += int'(rd_en);
      end
    end
  end

  task automatic do_cmd(input logic wr, input logic [7:0] a, input logic [15:0] d, input int hold);
    int w0, r0, n;
    logic legal;
    logic [15:0] exp_rd;
    legal  = (a <= 8'(MAX_ADDR));
    exp_rd = (!wr && legal) ? ref_mem[a[2:0]] : 16'h0;
    if (wr && legal) ref_mem[a[2:0]] = d;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      check("ready_timeout", 0, 1);
      return;
    end
    w0 = wr_cnt;
    r0 = rd_cnt;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = d;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_write = 1'($urandom);
    cmd_addr  = 8'($urandom);
    cmd_wdata = 16'($urandom);
    check("t1_wr_en", 64'(wr_en), 64'(wr && legal));
    check("t1_rd_en", 64'(rd_en), 64'(!wr && legal));
    check("t1_addr", 64'(addr), legal ? 64'(a) : 64'd0);
    check("t1_wdata", 64'(wr_data), (wr && legal) ? 64'(d) : 64'd0);
    check("t1_cmd_ready", 64'(cmd_ready), 0);
    check("t1_busy", 64'(busy), 1);
    check("t1_rsp_valid", 64'(rsp_valid), 0);
    @(negedge clk);
    check("t2_rsp_valid", 64'(rsp_valid), 1);
    check("t2_rdata", 64'(rsp_rdata), 64'(exp_rd));
    check("t2_err", 64'(rsp_err), 64'(!legal));
    check("t2_strobes", {62'd0, wr_en, rd_en}, 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_rsp", {rsp_valid, rsp_err, rsp_rdata}, {1'b1, !legal, exp_rd});
      check("hold_cmd_ready", 64'(cmd_ready), 0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("post_rsp_valid", 64'(rsp_valid), 0);
    check("post_cmd_ready", 64'(cmd_ready), 1);
    check("post_busy", 64'(busy), 0);
    check("wr_count", 64'(wr_cnt - w0), 64'(wr && legal));
    check("rd_count", 64'(rd_cnt - r0), 64'(!wr && legal));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 8; i++) ref_mem[i] = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          {cmd_ready, rsp_valid, rsp_rdata, rsp_err, wr_en, rd_en, addr, wr_data, busy}, 0);
    rst_n = 1'b1;

`ifdef PWM_REG_MASTER_BOOT_EN
    begin
      logic [7:0]  exp_a [7];
      logic [15:0] exp_d [7];
      logic [7:0]  got_a [$];
      logic [15:0] got_d [$];
      int n;
      exp_a = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd0};
      exp_d = '{16'h0000, 16'hFFFF, 16'h0000, 16'h8000, 16'h0001, 16'h0000, 16'h0001};
      n = 0;
      do begin
        @(negedge clk);
        n++;
        if (wr_en) begin
          got_a.push_back(addr);
          got_d.push_back(wr_data);
          check("boot_busy", 64'(busy), 1);
          check("boot_cmd_ready", 64'(cmd_ready), 0);
          check("boot_consecutive", 64'(got_a.size()), 64'(n - 1));
        end
      end while (!cmd_ready && n < 40);
      check("boot_count", 64'(got_a.size()), 7);
      for (int i = 0; i < 7 && i < got_a.size(); i++) begin
        check("boot_addr", 64'(got_a[i]), 64'(exp_a[i]));
        check("boot_data", 64'(got_d[i]), 64'(exp_d[i]));
      end
      for (int i = 0; i < 7; i++) ref_mem[exp_a[i][2:0]] = exp_d[i];
    end
`else
    @(negedge clk);
    check("idle_cmd_ready", 64'(cmd_ready), 1);
    check("idle_busy", 64'(busy), 0);
`endif

    do_cmd(1'b1, 8'd2, 16'h03E8, 0);
    do_cmd(1'b0, 8'd2, 16'h0000, 1);
    do_cmd(1'b1, 8'd7, 16'h1234, 2);
    do_cmd(1'b0, 8'd7, 16'h0000, 0);
    do_cmd(1'b0, 8'hFF, 16'h0000, 0);
    do_cmd(1'b1, 8'd6, 16'hA5A5, 5);
    do_cmd(1'b0, 8'd6, 16'h0000, 5);
    do_cmd(1'b1, 8'd0, 16'h0001, 0);
    for (int k = 0; k < 40; k++) begin
      do_cmd(1'($urandom), 8'($urandom_range(0, 9)), 16'($urandom), int'($urandom_range(0, 3)));
    end

`ifndef PWM_REG_MASTER_BOOT_EN
    begin
      int n;
      n = 0;
      while (!cmd_ready && n < 50) begin
        @(negedge clk);
        n++;
      end
      cmd_valid = 1'b1;
      cmd_write = 1'b0;
      cmd_addr  = 8'd2;
      @(negedge clk);
      cmd_valid = 1'b0;
      check("rst_mid_rd_en", 64'(rd_en), 1);
      #2 rst_n = 1'b0;
      #1;
      check("rst_mid_outputs",
            {cmd_ready, rsp_valid, rsp_rdata, rsp_err, wr_en, rd_en, addr, wr_data, busy}, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        check("rst_no_rsp", 64'(rsp_valid), 0);
      end
      check("rst_cmd_ready", 64'(cmd_ready), 1);
      do_cmd(1'b0, 8'd2, 16'h0000, 0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
